dfu_store_seq: RTL and testbench

//  DFU store sequencer. Pops one store instruction from the IDU store FIFO and programs the arbiter CU registers once per row (length, SRAM addr, DRAM addr).
//  Per row: pulses a read interrupt, then waits for the SRAM read-done. Unlike the fixed-ROW store path, row count and row length come from the instruction, the DRAM stride is a parameter, and a watchdog timeout reports errors.

---
 rtl/dfu_pkg.sv | 29 ++
 rtl/store_addr_gen.sv | 47 ++++
 rtl/dfu_store_seq.sv | 166 ++++++++++++++++
 tb/tb_dfu_store_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfu_pkg.sv
// Shared definitions for the DFU store sequencer: instruction field layout,
// arbiter register map defaults and the sequencer state encoding.
package dfu_pkg;

  localparam int ROWS_W = 16;
  localparam int LEN_W  = 16;

  // Word indices (in units of FIFO_WIDTH) of the instruction fields; word 0 is unused.
  localparam int SRAM_WORD = 1;
  localparam int DRAM_WORD = 2;
  localparam int CTRL_WORD = 3;

  localparam int CU_LENGTH_DEF    = 0;
  localparam int CU_SRAM_ADDR_DEF = 1;
  localparam int CU_DRAM_ADDR_DEF = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_FETCH,
    S_WR_LEN,
    S_WR_SRAM,
    S_WR_DRAM,
    S_WAIT_AR_ACK,
    S_WAIT_SRAM,
    S_DONE
  } state_t;

endpackage

// File: rtl/store_addr_gen.sv
// Per-row address generator: SRAM/DRAM running accumulators and the row counter.
// DRAM addresses advance by a constant stride so no multiplier is needed.
module store_addr_gen
  import dfu_pkg::*;
#(
  parameter int W    = 32,
  parameter int C_EL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [W-1:0]      sram_base,
  input  logic [W-1:0]      dram_base,
  input  logic [ROWS_W-1:0] rows,
  output logic [W-1:0]      sram_addr,
  output logic [W-1:0]      dram_addr,
  output logic              last_row
);

  localparam int RW1 = ROWS_W + 1;

  logic [ROWS_W-1:0] row_cnt;
  logic [ROWS_W-1:0] rows_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr <= '0;
      dram_addr <= '0;
      row_cnt   <= '0;
      rows_q    <= '0;
    end else if (load) begin
      sram_addr <= sram_base;
      dram_addr <= dram_base;
      row_cnt   <= '0;
      rows_q    <= rows;
    end else if (step) begin
      sram_addr <= sram_addr + W'(1);
      dram_addr <= dram_addr + W'(C_EL);
      row_cnt   <= row_cnt + ROWS_W'(1);
    end
  end

  // Extra bit keeps r+1 from wrapping when rows is at its maximum.
  assign last_row = (({1'b0, row_cnt} + RW1'(1)) == {1'b0, rows_q});

endmodule

// File: rtl/dfu_store_seq.sv
// DFU store sequencer: pops one store instruction and, for each row, programs the
// arbiter CU registers, fires a read interrupt and waits for the SRAM read to finish.
module dfu_store_seq
  import dfu_pkg::*;
#(
  parameter int FIFO_WIDTH   = 32,
  parameter int INSTR_WIDTH  = 128,
  parameter int C_EL         = 64,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int CU_LENGTH    = CU_LENGTH_DEF,
  parameter int CU_SRAM_ADDR = CU_SRAM_ADDR_DEF,
  parameter int CU_DRAM_ADDR = CU_DRAM_ADDR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idu2dfu_store_fifo_empty,
  output logic                   dfu2idu_store_instr_req,
  input  logic [INSTR_WIDTH-1:0] idu2dfu_store_instr,
  input  logic                   idu2dfu_store_instr_vld,
  output logic                   dfu2ar_grant_req,
  input  logic                   ar2dfu_grant,
  output logic                   dfu2ar_rd_req,
  output logic [FIFO_WIDTH-1:0]  dfu2ar_rd_addr,
  output logic                   dfu2ar_rd_addr_vld,
  output logic [FIFO_WIDTH-1:0]  dfu2ar_rd_data_out,
  output logic                   dfu2ar_rd_data_out_vld,
  input  logic                   ar2dfu_ack,
  input  logic                   ack_sram_c_rd,
  output logic                   dfu2ar_read_interrupt,
  output logic                   dfu2idu_store_done,
  output logic                   dfu2idu_store_err,
  output logic                   dfu_store_busy
);

  localparam int W     = FIFO_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [LEN_W-1:0]  row_len_q;
  logic              err_q, int_q;
  logic              load, step, err_set, timeout, in_wait, wr_fire;
  logic [W-1:0]      sram_addr, dram_addr;
  logic              last_row;
  logic [ROWS_W-1:0] instr_rows;
  logic              unused_low_word;

  assign instr_rows      = idu2dfu_store_instr[CTRL_WORD*W +: ROWS_W];
  assign unused_low_word = ^idu2dfu_store_instr[W-1:0];

  store_addr_gen #(.W(W), .C_EL(C_EL)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .sram_base (idu2dfu_store_instr[SRAM_WORD*W +: W]),
    .dram_base (idu2dfu_store_instr[DRAM_WORD*W +: W]),
    .rows      (instr_rows),
    .sram_addr (sram_addr),
    .dram_addr (dram_addr),
    .last_row  (last_row)
  );

  assign in_wait = (state == S_WAIT_AR_ACK) || (state == S_WAIT_SRAM);
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      row_len_q <= '0;
      err_q     <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      // The watchdog only counts while parked in a wait state and restarts on any transition.
      if (state_nxt != state || !in_wait)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (load)
        row_len_q <= idu2dfu_store_instr[CTRL_WORD*W + ROWS_W +: LEN_W];
      if (err_set)
        err_q <= 1'b1;
      else if (state == S_DONE)
        err_q <= 1'b0;
      int_q <= (state == S_WAIT_AR_ACK) && ar2dfu_ack;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE:    if (!idu2dfu_store_fifo_empty) state_nxt = S_REQ;
      S_REQ:     state_nxt = S_FETCH;
      S_FETCH: begin
        if (idu2dfu_store_instr_vld) begin
          load      = 1'b1;
          state_nxt = (instr_rows == '0) ? S_DONE : S_WR_LEN;
        end
      end
      S_WR_LEN:  if (ar2dfu_grant) state_nxt = S_WR_SRAM;
      S_WR_SRAM: if (ar2dfu_grant) state_nxt = S_WR_DRAM;
      S_WR_DRAM: if (ar2dfu_grant) state_nxt = S_WAIT_AR_ACK;
      // A coincident SRAM ack here is deliberately dropped; it must come in WAIT_SRAM.
      S_WAIT_AR_ACK: begin
        if (ar2dfu_ack) begin
          state_nxt = S_WAIT_SRAM;
        end else if (timeout) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end
      end
      S_WAIT_SRAM: begin
        if (ack_sram_c_rd) begin
          step      = 1'b1;
          state_nxt = last_row ? S_DONE : S_WR_LEN;
        end else if (timeout) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign wr_fire = ar2dfu_grant &&
                   ((state == S_WR_LEN) || (state == S_WR_SRAM) || (state == S_WR_DRAM));

  always_comb begin
    dfu2ar_rd_addr     = '0;
    dfu2ar_rd_data_out = '0;
    if (wr_fire) begin
      case (state)
        S_WR_LEN: begin
          dfu2ar_rd_addr     = W'(CU_LENGTH);
          dfu2ar_rd_data_out = W'(row_len_q);
        end
        S_WR_SRAM: begin
          dfu2ar_rd_addr     = W'(CU_SRAM_ADDR);
          dfu2ar_rd_data_out = sram_addr;
        end
        default: begin
          dfu2ar_rd_addr     = W'(CU_DRAM_ADDR);
          dfu2ar_rd_data_out = dram_addr;
        end
      endcase
    end
  end

  assign dfu2ar_rd_req           = wr_fire;
  assign dfu2ar_rd_addr_vld      = wr_fire;
  assign dfu2ar_rd_data_out_vld  = wr_fire;
  assign dfu2ar_grant_req        = (state == S_WR_LEN) || (state == S_WR_SRAM) ||
                                   (state == S_WR_DRAM) || in_wait;
  assign dfu2idu_store_instr_req = (state == S_REQ);
  assign dfu2idu_store_done      = (state == S_DONE);
  assign dfu2idu_store_err       = (state == S_DONE) && err_q;
  assign dfu2ar_read_interrupt   = int_q;
  assign dfu_store_busy          = (state != S_IDLE);

endmodule

// File: tb/tb_dfu_store_seq.sv
// Self-checking bench for dfu_store_seq: table-driven row programming runs plus
// directed sequences for grant loss, watchdog timeout and mid-operation reset.
module tb_dfu_store_seq;

  localparam int W   = 32;
  localparam int IW  = 128;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          instr_req;
  logic [IW-1:0] instr = '0;
  logic          instr_vld = 1'b0;
  logic          grant_req;
  logic          grant = 1'b1;
  logic          rd_req;
  logic [W-1:0]  rd_addr;
  logic          rd_addr_vld;
  logic [W-1:0]  rd_data;
  logic          rd_data_vld;
  logic          ar_ack = 1'b0;
  logic          sram_ack = 1'b0;
  logic          read_int;
  logic          done;
  logic          err;
  logic          busy;

  always #5 clk = ~clk;

  dfu_store_seq #(
    .FIFO_WIDTH (W),
    .INSTR_WIDTH(IW),
    .C_EL       (64),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .idu2dfu_store_fifo_empty(fifo_empty),
    .dfu2idu_store_instr_req (instr_req),
    .idu2dfu_store_instr     (instr),
    .idu2dfu_store_instr_vld (instr_vld),
    .dfu2ar_grant_req        (grant_req),
    .ar2dfu_grant            (grant),
    .dfu2ar_rd_req           (rd_req),
    .dfu2ar_rd_addr          (rd_addr),
    .dfu2ar_rd_addr_vld      (rd_addr_vld),
    .dfu2ar_rd_data_out      (rd_data),
    .dfu2ar_rd_data_out_vld  (rd_data_vld),
    .ar2dfu_ack              (ar_ack),
    .ack_sram_c_rd           (sram_ack),
    .dfu2ar_read_interrupt   (read_int),
    .dfu2idu_store_done      (done),
    .dfu2idu_store_err       (err),
    .dfu_store_busy          (busy)
  );

  typedef struct {
    logic [31:0] sram;
    logic [31:0] dram;
    logic [15:0] rows;
    logic [15:0] len;
    logic [31:0] last_sram;
    logic [31:0] last_dram;
    int          exp_int;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vld_cd = 0, ar_cd = 0, sram_cd = 0;
  bit sram_auto = 1'b1;
  logic grant_nxt = 1'b1;
  logic [IW-1:0] pending = '0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int int_cnt = 0, done_cnt = 0, err_cnt = 0, gr_cnt = 0;
  int int_cyc = 0, done_cyc = 0, err_cyc = 0, pop_cyc = 0;
  logic done_gr = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: grant applied just after the rising edge, then the FIFO/arbiter/SRAM
  // models respond and outputs are recorded at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1 grant = grant_nxt;
    @(negedge clk);
    cyc++;
    instr_vld = 1'b0;
    ar_ack    = 1'b0;
    sram_ack  = 1'b0;
    if (vld_cd > 0) begin
      vld_cd--;
      if (vld_cd == 0) begin instr_vld = 1'b1; instr = pending; end
    end
    if (ar_cd > 0) begin
      ar_cd--;
      if (ar_cd == 0) ar_ack = 1'b1;
    end
    if (sram_cd > 0) begin
      sram_cd--;
      if (sram_cd == 0) sram_ack = 1'b1;
    end
    if (rd_req) begin
      wr_addr.push_back(rd_addr);
      wr_data.push_back(rd_data);
      if (rd_addr == 32'd2) ar_cd = 2;
    end
    if (read_int) begin
      int_cnt++;
      int_cyc = cyc;
      if (sram_auto) sram_cd = 2;
    end
    if (done) begin done_cnt++; done_cyc = cyc; done_gr = grant_req; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (grant_req) gr_cnt++;
    if (instr_req) begin pop_cyc = cyc; fifo_empty = 1'b1; vld_cd = 3; end
  endtask

  task automatic loadInstr(input logic [31:0] sram, input logic [31:0] dram,
                           input logic [15:0] rows, input logic [15:0] len);
    pending    = {len, rows, dram, sram, 32'hDEADBEEF};
    fifo_empty = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] sram, input logic [31:0] dram,
                               input logic [15:0] rows, input logic [15:0] len, output bit ok);
    int base;
    base = done_cnt;
    ok = 1'b0;
    loadInstr(sram, dram, rows, len);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done_cnt != base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitDone(input int limit, output bit ok);
    int base;
    base = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt != base) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[3];
    bit ok;
    int wb, ib, eb, db, gb, n;
    logic [31:0] d_exp;

    vecs[0] = '{sram: 32'h100,      dram: 32'h4000,     rows: 16'd3, len: 16'd16,
                last_sram: 32'h102, last_dram: 32'h4080, exp_int: 3};
    vecs[1] = '{sram: 32'hFFFFFFFF, dram: 32'hFFFFFFC0, rows: 16'd2, len: 16'd8,
                last_sram: 32'h0,   last_dram: 32'h0,    exp_int: 2};
    vecs[2] = '{sram: 32'h20,       dram: 32'h1000,     rows: 16'd1, len: 16'hFFFF,
                last_sram: 32'h20,  last_dram: 32'h1000, exp_int: 1};

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_req", grant_req, 0);
    checkOutput("rst_rd_req", rd_req, 0);
    checkOutput("rst_addr_vld", rd_addr_vld, 0);
    checkOutput("rst_data_vld", rd_data_vld, 0);
    checkOutput("rst_addr", rd_addr, 0);
    checkOutput("rst_data", rd_data, 0);
    checkOutput("rst_instr_req", instr_req, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_interrupt", read_int, 0);
    rst = 1'b1;
    tick(); tick();

    for (int v = 0; v < 3; v++) begin
      wb = wr_addr.size(); ib = int_cnt; eb = err_cnt; db = done_cnt;
      applyStimulus(vecs[v].sram, vecs[v].dram, vecs[v].rows, vecs[v].len, ok);
      checkOutput($sformatf("v%0d_done_seen", v), ok, 1);
      tick(); tick();
      n = wr_addr.size() - wb;
      checkOutput($sformatf("v%0d_write_count", v), n, 3 * vecs[v].rows);
      checkOutput($sformatf("v%0d_interrupts", v), int_cnt - ib, vecs[v].exp_int);
      checkOutput($sformatf("v%0d_done_count", v), done_cnt - db, 1);
      checkOutput($sformatf("v%0d_err_count", v), err_cnt - eb, 0);
      checkOutput($sformatf("v%0d_idle", v), busy, 0);
      if (n == 3 * vecs[v].rows && n > 0) begin
        checkOutput($sformatf("v%0d_last_sram", v), wr_data[wb + n - 2], vecs[v].last_sram);
        checkOutput($sformatf("v%0d_last_dram", v), wr_data[wb + n - 1], vecs[v].last_dram);
        d_exp = vecs[v].dram;
        for (int r = 0; r < vecs[v].rows; r++) begin
          checkOutput($sformatf("v%0d_r%0d_len_addr", v, r), wr_addr[wb + 3*r], 0);
          checkOutput($sformatf("v%0d_r%0d_len_data", v, r), wr_data[wb + 3*r], {16'd0, vecs[v].len});
          checkOutput($sformatf("v%0d_r%0d_sram_addr", v, r), wr_addr[wb + 3*r + 1], 1);
          checkOutput($sformatf("v%0d_r%0d_sram_data", v, r), wr_data[wb + 3*r + 1], vecs[v].sram + 32'(r));
          checkOutput($sformatf("v%0d_r%0d_dram_addr", v, r), wr_addr[wb + 3*r + 2], 2);
          checkOutput($sformatf("v%0d_r%0d_dram_data", v, r), wr_data[wb + 3*r + 2], d_exp);
          d_exp = d_exp + 32'd64;
        end
      end
    end

    // rows == 0: done four cycles after the pop (FIFO model returns data 3 cycles after it).
    wb = wr_addr.size(); gb = gr_cnt; ib = int_cnt;
    applyStimulus(32'h10, 32'h20, 16'd0, 16'd5, ok);
    checkOutput("zero_done_seen", ok, 1);
    checkOutput("zero_done_latency", done_cyc - pop_cyc, 4);
    checkOutput("zero_grant_req_cycles", gr_cnt - gb, 0);
    checkOutput("zero_writes", wr_addr.size() - wb, 0);
    checkOutput("zero_interrupts", int_cnt - ib, 0);
    tick();

    // Grant withdrawn for 5 cycles while row 1 is in WR_SRAM.
    wb = wr_addr.size();
    loadInstr(32'h200, 32'h8000, 16'd2, 16'd4);
    for (int i = 0; i < 100 && wr_addr.size() < wb + 4; i++) tick();
    checkOutput("drop_reached_row1", wr_addr.size() - wb, 4);
    grant_nxt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("drop_rd_req_c%0d", i), rd_req, 0);
      checkOutput($sformatf("drop_grant_req_c%0d", i), grant_req, 1);
    end
    grant_nxt = 1'b1;
    waitDone(100, ok);
    checkOutput("drop_done_seen", ok, 1);
    tick(); tick();
    n = wr_addr.size() - wb;
    checkOutput("drop_write_count", n, 6);
    if (n == 6) begin
      checkOutput("drop_reissue_addr", wr_addr[wb + 4], 1);
      checkOutput("drop_reissue_data", wr_data[wb + 4], 32'h201);
      checkOutput("drop_row1_dram", wr_data[wb + 5], 32'h8040);
    end

    // SRAM ack withheld: watchdog fires TMO cycles after entering WAIT_SRAM.
    sram_auto = 1'b0;
    wb = wr_addr.size(); ib = int_cnt; eb = err_cnt;
    applyStimulus(32'h400, 32'h500, 16'd2, 16'd1, ok);
    checkOutput("tmo_done_seen", ok, 1);
    checkOutput("tmo_err_count", err_cnt - eb, 1);
    checkOutput("tmo_latency", done_cyc - int_cyc, TMO);
    checkOutput("tmo_err_with_done", err_cyc, done_cyc);
    checkOutput("tmo_grant_req_at_done", done_gr, 0);
    checkOutput("tmo_interrupts", int_cnt - ib, 1);
    checkOutput("tmo_writes", wr_addr.size() - wb, 3);
    tick();
    checkOutput("tmo_idle", busy, 0);
    checkOutput("tmo_err_cleared", err, 0);

    // Reset while parked in WAIT_SRAM, then a normal instruction.
    ib = int_cnt;
    loadInstr(32'h300, 32'h100, 16'd2, 16'd2);
    for (int i = 0; i < 100 && int_cnt == ib; i++) tick();
    checkOutput("rstmid_reached_wait", int_cnt - ib, 1);
    tick(); tick();
    checkOutput("rstmid_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_grant_req", grant_req, 0);
    checkOutput("rstmid_rd_req", rd_req, 0);
    checkOutput("rstmid_done", done, 0);
    checkOutput("rstmid_err", err, 0);
    checkOutput("rstmid_interrupt", read_int, 0);
    vld_cd = 0; ar_cd = 0; sram_cd = 0;
    sram_auto = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    wb = wr_addr.size(); eb = err_cnt;
    applyStimulus(32'h100, 32'h4000, 16'd3, 16'd16, ok);
    checkOutput("post_rst_done_seen", ok, 1);
    tick();
    n = wr_addr.size() - wb;
    checkOutput("post_rst_writes", n, 9);
    checkOutput("post_rst_err", err_cnt - eb, 0);
    if (n == 9) checkOutput("post_rst_last_dram", wr_data[wb + 8], 32'h4080);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
